fft_mem_port_arbiter: RTL

- Shares the single 128-bit-word memory port between two streaming channels of the FFT accelerator.
  - Channel 0 is the input-read stream.
  - Channel 1 is the output-write stream.
- Each channel is configured with a base word offset and a filesize in 128-bit words.
- The block generates word addresses (offset + index), arbitrates round-robin per word, holds each request until memory acknowledges it, and reports per-channel busy/done.
- It sits between the FFT core's stream buffers and the memory controller.

---
 rtl/fft_mem_pkg.sv | 13 +
 rtl/fft_chan_ctx.sv | 54 +++++
 rtl/fft_mem_port_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/fft_mem_pkg.sv
// Shared definitions for the FFT memory-port arbiter: address width default,
// arbiter FSM encodings and channel indices.
package fft_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam int unsigned CH_RD = 0;
  localparam int unsigned CH_WR = 1;

endpackage

// File: rtl/fft_chan_ctx.sv
// Per-channel stream context: latches base offset and length on start,
// tracks the word index and produces the current word address.
module fft_chan_ctx
  import fft_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_offset,
  input  logic [ADDR_W-1:0] cfg_filesize,
  input  logic              xfer,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] filesize;
  logic [ADDR_W-1:0] index;
  logic              last;

  // Address wraps modulo 2^ADDR_W; carry is intentionally dropped.
  assign addr = offset + index;
  assign last = ((index + ADDR_W'(1)) == filesize);

  always_ff @(posedge clk) begin
    if (reset) begin
      offset   <= '0;
      filesize <= '0;
      index    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        offset   <= cfg_offset;
        filesize <= cfg_filesize;
        index    <= '0;
        // An empty file completes immediately without ever becoming busy.
        busy     <= (cfg_filesize != '0);
        done     <= (cfg_filesize == '0);
      end else if (xfer) begin
        index <= index + ADDR_W'(1);
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fft_mem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit-word memory port between the FFT
// input-read stream (channel 0) and output-write stream (channel 1).
module fft_mem_port_arbiter
  import fft_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        start,
  input  logic [ADDR_W-1:0] offset0,
  input  logic [ADDR_W-1:0] filesize0,
  input  logic [ADDR_W-1:0] offset1,
  input  logic [ADDR_W-1:0] filesize1,
  input  logic [1:0]        ch_rdy,
  output logic [1:0]        ch_xfer,
  output logic [1:0]        busy,
  output logic [1:0]        done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack
);

  logic [0:0]        state;
  logic              grant;
  logic              rr_ptr;
  logic [1:0]        elig;
  logic              pick;
  logic              xfer_ok;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;

  fft_chan_ctx #(.ADDR_W(ADDR_W)) u_ctx_rd (
    .clk          (clk),
    .reset        (reset),
    .start        (start[CH_RD]),
    .cfg_offset   (offset0),
    .cfg_filesize (filesize0),
    .xfer         (ch_xfer[CH_RD]),
    .busy         (busy[CH_RD]),
    .done         (done[CH_RD]),
    .addr         (addr0)
  );

  fft_chan_ctx #(.ADDR_W(ADDR_W)) u_ctx_wr (
    .clk          (clk),
    .reset        (reset),
    .start        (start[CH_WR]),
    .cfg_offset   (offset1),
    .cfg_filesize (filesize1),
    .xfer         (ch_xfer[CH_WR]),
    .busy         (busy[CH_WR]),
    .done         (done[CH_WR]),
    .addr         (addr1)
  );

  assign elig    = busy & ch_rdy;
  // rr_ptr names the channel to prefer when both are eligible.
  assign pick    = (elig == 2'b11) ? rr_ptr : elig[1];
  assign xfer_ok = (state == ST_REQ) && mem_ack;
  assign ch_xfer = {xfer_ok && grant, xfer_ok && !grant};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant    <= 1'b0;
      rr_ptr   <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|elig) begin
            state    <= ST_REQ;
            grant    <= pick;
            mem_req  <= 1'b1;
            mem_we   <= pick;
            mem_addr <= pick ? addr1 : addr0;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            rr_ptr  <= !grant;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
